// File: rtl/image_rom_arbiter.sv
// image_rom_arbiter
//   Shares one combinational image ROM read port between two requesters.
//   Port 0 is display scan-out (may flag urgency), port 1 is the masking
//   engine. A grant registers the winner's address onto the ROM port; the
//   colour comes back one cycle later on the winner's private bus with a
//   single-cycle valid. Out-of-image addresses still take a slot but return
//   OOB_COLOR with the oob flag set.
// Ports:
//   clk, rst               clock, async active-high reset
//   req0/urg0/row0/col0    port 0 request, urgency, address
//   req1/row1/col1         port 1 request, address
//   gnt0/gnt1              combinational accept at this edge
//   rvalid*/rdata*/oob*    registered per-port read response
//   rom_row/rom_col        registered ROM address
//   rom_data               ROM colour for rom_row/rom_col
module image_rom_arbiter #(
  parameter int ROW_W    = 8,
  parameter int COL_W    = 9,
  parameter int DATA_W   = 12,
  parameter int IMG_ROWS = 240,
  parameter int IMG_COLS = 320,
  parameter logic [DATA_W-1:0] OOB_COLOR = 12'h000,
  parameter int MAX_URG  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              urg0,
  input  logic [ROW_W-1:0]  row0,
  input  logic [COL_W-1:0]  col0,
  input  logic              req1,
  input  logic [ROW_W-1:0]  row1,
  input  logic [COL_W-1:0]  col1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              oob0,
  output logic              oob1,
  output logic [ROW_W-1:0]  rom_row,
  output logic [COL_W-1:0]  rom_col,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int CNT_W = $clog2(MAX_URG + 1);
  localparam logic [CNT_W-1:0] URG_LIM = CNT_W'(MAX_URG);
  // One extra bit so a limit equal to 2**W still compares correctly.
  localparam logic [ROW_W:0] ROW_LIM = (ROW_W+1)'(IMG_ROWS);
  localparam logic [COL_W:0] COL_LIM = (COL_W+1)'(IMG_COLS);

  logic [CNT_W-1:0]  urg_cnt_q, urg_cnt_d;
  logic              last_gnt_q;  // 1 = port 1 won last
  logic              sel_q, pend_q, oob_q;
  logic [ROW_W-1:0]  rom_row_q;
  logic [COL_W-1:0]  rom_col_q;
  logic              rvalid0_q, rvalid1_q, oob0_q, oob1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic urg_take, win0, gnt_any, oob0_w, oob1_w;

  assign urg_take = req0 & req1 & urg0 & (urg_cnt_q < URG_LIM);
  // Port 0 wins when alone, when urgency is still within budget, or when
  // round-robin says it is port 0's turn (port 1 went last).
  assign win0    = req0 & (~req1 | urg_take | last_gnt_q);
  assign gnt0    = ~rst & win0;
  assign gnt1    = ~rst & req1 & ~win0;
  assign gnt_any = gnt0 | gnt1;

  assign oob0_w = ({1'b0, row0} >= ROW_LIM) | ({1'b0, col0} >= COL_LIM);
  assign oob1_w = ({1'b0, row1} >= ROW_LIM) | ({1'b0, col1} >= COL_LIM);

  // Urgent streak resets whenever port 1 is served or stops asking;
  // increments only below the limit, so it saturates by construction.
  always_comb begin
    urg_cnt_d = urg_cnt_q;
    if (~req1 | gnt1)  urg_cnt_d = '0;
    else if (urg_take) urg_cnt_d = urg_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      urg_cnt_q  <= '0;
      last_gnt_q <= 1'b1;
      sel_q      <= 1'b0;
      pend_q     <= 1'b0;
      oob_q      <= 1'b0;
      rom_row_q  <= '0;
      rom_col_q  <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      oob0_q     <= 1'b0;
      oob1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      urg_cnt_q <= urg_cnt_d;
      pend_q    <= gnt_any;
      if (gnt_any) begin
        last_gnt_q <= gnt1;
        sel_q      <= gnt1;
        rom_row_q  <= gnt1 ? row1 : row0;
        rom_col_q  <= gnt1 ? col1 : col0;
        oob_q      <= gnt1 ? oob1_w : oob0_w;
      end
      rvalid0_q <= pend_q & ~sel_q;
      rvalid1_q <= pend_q & sel_q;
      if (pend_q && !sel_q) begin
        rdata0_q <= oob_q ? OOB_COLOR : rom_data;
        oob0_q   <= oob_q;
      end
      if (pend_q && sel_q) begin
        rdata1_q <= oob_q ? OOB_COLOR : rom_data;
        oob1_q   <= oob_q;
      end
    end
  end

  assign rom_row = rom_row_q;
  assign rom_col = rom_col_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign oob0    = oob0_q;
  assign oob1    = oob1_q;

endmodule

// File: tb/tb_image_rom_arbiter.sv
module tb_image_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, urg0, req1;
  logic [7:0]  row0, row1;
  logic [8:0]  col0, col1;
  logic        gnt0, gnt1, rvalid0, rvalid1, oob0, oob1;
  logic [11:0] rdata0, rdata1, rom_data;
  logic [7:0]  rom_row;
  logic [8:0]  rom_col;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // ROM model: arbitrary but address-unique-enough pattern, nonzero at (0,0).
  function automatic logic [11:0] rom_f(logic [7:0] r, logic [8:0] c);
    return {r, 4'h0} ^ {3'b000, c} ^ 12'h5A5;
  endfunction

  assign rom_data = rom_f(rom_row, rom_col);

  image_rom_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .urg0(urg0), .row0(row0), .col0(col0),
    .req1(req1), .row1(row1), .col1(col1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .oob0(oob0), .oob1(oob1),
    .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data)
  );

  typedef struct {
    logic       r0, u0, r1;
    logic [7:0] row0, row1;
    logic [8:0] col0, col1;
    logic       g0, g1, oob;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int r0, int u0, int rw0, int cl0,
                              int r1, int rw1, int cl1,
                              int g0, int g1, int ob);
    vec_t v;
    v.r0 = 1'(r0); v.u0 = 1'(u0); v.row0 = 8'(rw0); v.col0 = 9'(cl0);
    v.r1 = 1'(r1); v.row1 = 8'(rw1); v.col1 = 9'(cl1);
    v.g0 = 1'(g0); v.g1 = 1'(g1); v.oob = 1'(ob);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected response of the previous vector, and held rdata per port.
  logic        p_g0 = 0, p_g1 = 0, p_oob = 0;
  logic [11:0] p_data = 0;
  logic [11:0] exp_rd0 = 0, exp_rd1 = 0;

  task automatic drive(vec_t v);
    req0 = v.r0; urg0 = v.u0; row0 = v.row0; col0 = v.col0;
    req1 = v.r1; row1 = v.row1; col1 = v.col1;
  endtask

  // Called at a negedge: apply, check grant, clock, check previous
  // vector's response and this vector's ROM address, return at negedge.
  task automatic step(vec_t v, int idx);
    logic [7:0] wr;
    logic [8:0] wc;
    drive(v);
    #1;
    chk($sformatf("gnt0[%0d]", idx), 32'(gnt0), 32'(v.g0));
    chk($sformatf("gnt1[%0d]", idx), 32'(gnt1), 32'(v.g1));
    @(posedge clk); #1;
    if (p_g0) exp_rd0 = p_data;
    if (p_g1) exp_rd1 = p_data;
    chk($sformatf("rvalid0[%0d]", idx), 32'(rvalid0), 32'(p_g0));
    chk($sformatf("rvalid1[%0d]", idx), 32'(rvalid1), 32'(p_g1));
    chk($sformatf("rdata0[%0d]", idx), 32'(rdata0), 32'(exp_rd0));
    chk($sformatf("rdata1[%0d]", idx), 32'(rdata1), 32'(exp_rd1));
    if (p_g0) chk($sformatf("oob0[%0d]", idx), 32'(oob0), 32'(p_oob));
    if (p_g1) chk($sformatf("oob1[%0d]", idx), 32'(oob1), 32'(p_oob));
    p_g0 = v.g0; p_g1 = v.g1; p_oob = v.oob;
    if (v.g0 || v.g1) begin
      wr = v.g1 ? v.row1 : v.row0;
      wc = v.g1 ? v.col1 : v.col0;
      p_data = v.oob ? 12'h000 : rom_f(wr, wc);
      chk($sformatf("rom_row[%0d]", idx), 32'(rom_row), 32'(wr));
      chk($sformatf("rom_col[%0d]", idx), 32'(rom_col), 32'(wc));
    end
    @(negedge clk);
  endtask

  initial begin
    // Port 1 alone first so the round-robin burst starts on port 0.
    vecs.push_back(mk(0,0,0,0, 1,10,20, 0,1,0));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(1,0,k+1,k+2, 1,k+50,k+100, (k%2==0),(k%2==1),0));
    // Urgent override bounded at 4 consecutive port-0 wins.
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(1,1,k+3,k*7, 1,k+60,k*9, (k!=4 && k!=9),(k==4 || k==9),0));
    // Boundary addresses.
    vecs.push_back(mk(1,0,239,319, 0,0,0,   1,0,0));
    vecs.push_back(mk(1,0,240,0,   0,0,0,   1,0,1));
    vecs.push_back(mk(1,0,0,320,   0,0,0,   1,0,1));
    vecs.push_back(mk(1,0,255,511, 0,0,0,   1,0,1));
    vecs.push_back(mk(0,0,0,0,     1,240,319, 0,1,1));
    vecs.push_back(mk(0,0,0,0,     1,239,0,   0,1,0));
    vecs.push_back(mk(0,0,0,0,     0,0,0,     0,0,0));
    // Port 1 back-to-back burst; rdata0 must stay put.
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0,0,0,0, 1,k*20,k*30+1, 0,1,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0,0));

    // Reset state, grants suppressed while rst is high.
    rst = 1'b1;
    drive(mk(1,1,5,5, 1,6,6, 0,0,0));
    #12;
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 0);
    chk("rst_rdata", {8'd0, rdata1, rdata0}, 0);
    chk("rst_rom", {15'd0, rom_row, rom_col}, 0);
    chk("rst_oob", {30'd0, oob1, oob0}, 0);
    @(negedge clk);
    drive(mk(0,0,0,0, 0,0,0, 0,0,0));
    rst = 1'b0;

    foreach (vecs[i]) step(vecs[i], i);

    // Reset mid-burst: responses in flight must vanish asynchronously.
    drive(mk(1,0,7,8, 1,9,10, 0,0,0));
    @(posedge clk); @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rvalid", {30'd0, rvalid1, rvalid0}, 0);
    chk("mid_rdata", {8'd0, rdata1, rdata0}, 0);
    chk("mid_rom", {15'd0, rom_row, rom_col}, 0);
    chk("mid_gnt", {30'd0, gnt1, gnt0}, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    drive(mk(1,0,0,0, 0,0,0, 0,0,0));
    #1;
    chk("post_gnt0", 32'(gnt0), 1);
    chk("post_gnt1", 32'(gnt1), 0);
    @(posedge clk); #1;
    chk("post_no_stale_rvalid", {30'd0, rvalid1, rvalid0}, 0);
    @(negedge clk);
    drive(mk(0,0,0,0, 0,0,0, 0,0,0));
    @(posedge clk); #1;
    chk("post_rvalid0", 32'(rvalid0), 1);
    chk("post_rdata0", 32'(rdata0), 32'h5A5);
    chk("post_oob0", 32'(oob0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
